// File: rtl/dice_score_pkg.sv
// dice_score_pkg: shared state encoding and saturating score increment
// for the dice referee.
package dice_score_pkg;

    typedef enum logic [2:0] {COLLECT, RESOLVE, JUDGE, HOLD, FINAL} state_t;

    function automatic int unsigned sat_inc(input int unsigned v, input int unsigned max_v);
        return (v >= max_v) ? max_v : v + 1;
    endfunction

endpackage

// File: rtl/dice_score_ctrl_if.sv
// dice_score_ctrl_if: dice inputs and score/display outputs of the referee;
// master is the dice/display side, slave is the referee.
interface dice_score_ctrl_if #(
    parameter int N_PLAYERS = 2,
    parameter int DICE_W    = 4,
    parameter int SCORE_W   = 4
);
    localparam int WW = $clog2(N_PLAYERS);

    logic [N_PLAYERS-1:0]         start;
    logic [N_PLAYERS*DICE_W-1:0]  dice;
    logic [N_PLAYERS*SCORE_W-1:0] score;
    logic [N_PLAYERS-1:0]         thrown;
    logic                         busy;
    logic                         is_final;
    logic                         finish;
    logic [WW-1:0]                winner;

    modport master (output start, dice, input score, thrown, busy, is_final, finish, winner);
    modport slave  (input start, dice, output score, thrown, busy, is_final, finish, winner);
endinterface

// File: rtl/dice_argmax.sv
// dice_argmax: combinational maximum over the latched throws, with the mask
// of players holding it and a flag for a single holder.
module dice_argmax #(
    parameter int N = 2,
    parameter int W = 4
) (
    input  logic [N*W-1:0] vals,
    output logic [W-1:0]   max_v,
    output logic [N-1:0]   holders,
    output logic           uniq
);
    always_comb begin
        max_v = '0;
        for (int i = 0; i < N; i++)
            max_v = (vals[i*W +: W] > max_v) ? vals[i*W +: W] : max_v;
        for (int i = 0; i < N; i++)
            holders[i] = (vals[i*W +: W] == max_v);
        uniq = $onehot(holders);
    end
endmodule

// File: rtl/dice_score_ctrl.sv
// dice_score_ctrl: N-player dice referee (collect, score, judge, display hold).
// Define DICE_SCORE_TIE_SPLIT_EN to give every player sharing the max a point.
module dice_score_ctrl
    import dice_score_pkg::*;
#(
    parameter int N_PLAYERS    = 2,
    parameter int DICE_W       = 4,
    parameter int SCORE_W      = 4,
    parameter int WIN_MARGIN   = 2,
    parameter int HOLD_CYCLES  = 3_000_000,
    parameter int FINAL_CYCLES = 5_000_000
) (
    input logic clk,
    input logic rst,
    dice_score_ctrl_if.slave bus
);
    localparam int WW = $clog2(N_PLAYERS);
    localparam int MAXC = (HOLD_CYCLES > FINAL_CYCLES) ? HOLD_CYCLES : FINAL_CYCLES;
    localparam int CW = (MAXC > 1) ? $clog2(MAXC) : 1;
    localparam int unsigned SMAX = (1 << SCORE_W) - 1;

    state_t state_q, state_d;
    logic [N_PLAYERS-1:0] start_q, fall, thrown_q, thrown_d, holders, inc, lead;
    logic [N_PLAYERS*DICE_W-1:0] lat_q, lat_d;
    logic [N_PLAYERS*SCORE_W-1:0] score_q, score_d;
    logic [WW-1:0] winner_q, winner_d, lead_idx;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [DICE_W-1:0] max_unused;
    logic uniq, hold_last, final_last;

    dice_argmax #(.N(N_PLAYERS), .W(DICE_W)) u_argmax (
        .vals(lat_q), .max_v(max_unused), .holders(holders), .uniq(uniq)
    );

`ifdef DICE_SCORE_TIE_SPLIT_EN
    assign inc = holders;
`else
    assign inc = uniq ? holders : '0;
`endif

    assign fall       = start_q & ~bus.start;
    assign hold_last  = (state_q == HOLD) && (cnt_q == CW'(HOLD_CYCLES - 1));
    assign final_last = (state_q == FINAL) && (cnt_q == CW'(FINAL_CYCLES - 1));

    // Lowest qualifying index wins, so scan downwards and let lower p overwrite.
    always_comb begin
        lead = '1;
        lead_idx = '0;
        for (int p = N_PLAYERS - 1; p >= 0; p--) begin
            for (int j = 0; j < N_PLAYERS; j++)
                if (j != p && {1'b0, score_q[p*SCORE_W +: SCORE_W]} <
                    {1'b0, score_q[j*SCORE_W +: SCORE_W]} + (SCORE_W + 1)'(WIN_MARGIN))
                    lead[p] = 1'b0;
            if (lead[p]) lead_idx = WW'(p);
        end
    end

    always_comb begin
        state_d  = state_q;
        thrown_d = thrown_q;
        lat_d    = lat_q;
        score_d  = score_q;
        winner_d = winner_q;
        cnt_d    = cnt_q;
        case (state_q)
            COLLECT: begin
                for (int i = 0; i < N_PLAYERS; i++)
                    if (fall[i] && !thrown_q[i]) begin
                        lat_d[i*DICE_W +: DICE_W] = bus.dice[i*DICE_W +: DICE_W];
                        thrown_d[i] = 1'b1;
                    end
                state_d = (&thrown_d) ? RESOLVE : COLLECT;
            end
            RESOLVE: begin
                for (int i = 0; i < N_PLAYERS; i++)
                    if (inc[i])
                        score_d[i*SCORE_W +: SCORE_W] =
                            SCORE_W'(sat_inc(32'(score_q[i*SCORE_W +: SCORE_W]), SMAX));
                state_d = JUDGE;
            end
            JUDGE: begin
                state_d  = (|lead) ? FINAL : HOLD;
                winner_d = (|lead) ? lead_idx : winner_q;
            end
            HOLD: begin
                cnt_d    = hold_last ? '0 : cnt_q + 1'b1;
                thrown_d = hold_last ? '0 : thrown_q;
                state_d  = hold_last ? COLLECT : HOLD;
            end
            FINAL: begin
                cnt_d    = final_last ? '0 : cnt_q + 1'b1;
                thrown_d = final_last ? '0 : thrown_q;
                score_d  = final_last ? '0 : score_q;
                winner_d = final_last ? '0 : winner_q;
                state_d  = final_last ? COLLECT : FINAL;
            end
            default: state_d = COLLECT;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= COLLECT;
            start_q  <= '0;
            thrown_q <= '0;
            lat_q    <= '0;
            score_q  <= '0;
            winner_q <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            start_q  <= bus.start;
            thrown_q <= thrown_d;
            lat_q    <= lat_d;
            score_q  <= score_d;
            winner_q <= winner_d;
            cnt_q    <= cnt_d;
        end
    end

    assign bus.score    = score_q;
    assign bus.thrown   = thrown_q;
    assign bus.busy     = (state_q == HOLD) || (state_q == FINAL);
    assign bus.is_final = (state_q == FINAL);
    assign bus.finish   = hold_last || final_last;
    assign bus.winner   = (state_q == FINAL) ? winner_q : '0;
endmodule

// File: tb/tb_dice_score_ctrl.sv
// tb_dice_score_ctrl: directed rounds with a scoreboard of expected scores,
// final flag and winner, compared when each round's result appears.
module tb_dice_score_ctrl;
    localparam int N = 2, DW = 4, SW = 4, HC = 10, FC = 20;

    typedef struct {int sc0; int sc1; bit fin; int win;} exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int n_checks = 0;
    int n_err = 0;
    int s0 = 0, s1 = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

    dice_score_ctrl_if #(.N_PLAYERS(N), .DICE_W(DW), .SCORE_W(SW)) bus ();

    dice_score_ctrl #(
        .N_PLAYERS(N), .DICE_W(DW), .SCORE_W(SW), .WIN_MARGIN(2),
        .HOLD_CYCLES(HC), .FINAL_CYCLES(FC)
    ) dut (
        .clk(clk), .rst(rst), .bus(bus)
    );

    task automatic chk(input string tag, input int obs, input int exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_round(input int d0, input int d1);
        exp_t e;
        if (d0 > d1) s0++;
        else if (d1 > d0) s1++;
        else begin
`ifdef DICE_SCORE_TIE_SPLIT_EN
            s0++;
            s1++;
`endif
        end
        e.sc0 = s0;
        e.sc1 = s1;
        e.fin = (s0 >= s1 + 2) || (s1 >= s0 + 2);
        e.win = (s0 >= s1 + 2) ? 0 : 1;
        sb.push_back(e);
    endtask

    task automatic press(input int i, input int v);
        bus.dice[i*DW +: DW] = DW'(v);
        bus.start[i] = 1'b0;
        @(negedge clk);
        bus.start[i] = 1'b1;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_score"}, int'(bus.score), 0);
        chk({tag, "_thrown"}, int'(bus.thrown), 0);
        chk({tag, "_busy"}, int'(bus.busy), 0);
        chk({tag, "_final"}, int'(bus.is_final), 0);
        chk({tag, "_finish"}, int'(bus.finish), 0);
        chk({tag, "_winner"}, int'(bus.winner), 0);
    endtask

    // Entered on the falling edge right after the last throw edge was sampled.
    task automatic judge(input string tag);
        exp_t e;
        int len;
        chk({tag, "_thrown_all"}, int'(bus.thrown), 3);
        chk({tag, "_busy_resolve"}, int'(bus.busy), 0);
        @(negedge clk);
        e = sb.pop_front();
        chk({tag, "_score"}, int'(bus.score), (e.sc1 << SW) | e.sc0);
        chk({tag, "_busy_judge"}, int'(bus.busy), 0);
        @(negedge clk);
        len = e.fin ? FC : HC;
        for (int c = 1; c <= len; c++) begin
            chk({tag, "_busy"}, int'(bus.busy), 1);
            chk({tag, "_is_final"}, int'(bus.is_final), int'(e.fin));
            chk({tag, "_winner"}, int'(bus.winner), e.fin ? e.win : 0);
            chk({tag, "_finish"}, int'(bus.finish), int'(c == len));
            chk({tag, "_thrown_held"}, int'(bus.thrown), 3);
            if (c == 3) bus.start[0] = 1'b0;
            if (c == 4) bus.start[0] = 1'b1;
            @(negedge clk);
        end
        if (e.fin) begin
            s0 = 0;
            s1 = 0;
        end
        chk({tag, "_busy_after"}, int'(bus.busy), 0);
        chk({tag, "_finish_after"}, int'(bus.finish), 0);
        chk({tag, "_thrown_after"}, int'(bus.thrown), 0);
        chk({tag, "_winner_after"}, int'(bus.winner), 0);
        chk({tag, "_score_after"}, int'(bus.score), (s1 << SW) | s0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        bus.start = '1;
        bus.dice = '0;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b1;
        @(negedge clk);

        model_round(5, 3);
        press(0, 5);
        chk("t1_thrown_p0", int'(bus.thrown), 1);
        press(1, 3);
        judge("t1");

        model_round(4, 4);
        press(0, 4);
        press(1, 4);
        judge("t2");

        model_round(2, 6);
        bus.dice = {4'd6, 4'd2};
        bus.start = '0;
        @(negedge clk);
        bus.start = '1;
        judge("t3");

        model_round(6, 2);
        press(0, 6);
        press(0, 1);
        chk("t4_thrown_repeat", int'(bus.thrown), 1);
        press(1, 2);
        chk("t4_thrown_all", int'(bus.thrown), 3);
        @(negedge clk);
        begin
            exp_t e;
            e = sb.pop_front();
            chk("t4_score", int'(bus.score), (e.sc1 << SW) | e.sc0);
        end
        @(negedge clk);
        chk("t4_busy", int'(bus.busy), 1);
        repeat (4) @(negedge clk);
        #2 rst = 1'b0;
        #1 check_reset_outputs("t6_async");
        s0 = 0;
        s1 = 0;
        @(negedge clk);
        check_reset_outputs("t6_held");
        rst = 1'b1;
        @(negedge clk);

        model_round(3, 1);
        press(0, 3);
        press(1, 1);
        judge("t5_r1");
        model_round(4, 0);
        press(0, 4);
        press(1, 0);
        judge("t5_r2");

        model_round(1, 5);
        press(1, 5);
        chk("t7_thrown_p1", int'(bus.thrown), 2);
        press(0, 1);
        judge("t7_r1");
        model_round(2, 7);
        press(0, 2);
        press(1, 7);
        judge("t7_r2");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end
endmodule
